// File: rtl/core_seq_ctrl_pkg.sv
// core_seq_ctrl_pkg: shared state encoding, halt codes and memory-op constants for the sequencer.
package core_seq_ctrl_pkg;
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;
  localparam logic [1:0] HC_EBREAK   = 2'd0;
  localparam logic [1:0] HC_ILLEGAL  = 2'd1;
  localparam logic [1:0] HC_TIMEOUT  = 2'd2;
  localparam logic [1:0] HC_MISALIGN = 2'd3;
  localparam logic [1:0] MOP_NONE    = 2'b00;
  localparam logic [1:0] MOP_LOAD    = 2'b01;
  localparam logic [1:0] MOP_STORE   = 2'b10;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
endpackage

// File: rtl/core_seq_ctrl_wait_timer.sv
// seq_wait_timer: counts memory wait cycles; expired flags the last allowed cycle.
module seq_wait_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + 1'b1;
  end
  assign o_expired = r_cnt == TW'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer owning PC, halt and counters.
module core_seq_ctrl
  import core_seq_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC       = RESET_PC_DEF,
  parameter int                    TIMEOUT_CYCLES = 255,
  parameter int                    CNT_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ifu_req,
  output logic [ADDR_WIDTH-1:0] ifu_addr,
  input  logic                  ifu_ack,
  input  logic [31:0]           ifu_rdata,
  output logic [31:0]           inst,
  input  logic                  idu_illegal,
  input  logic                  idu_ebreak,
  input  logic [1:0]            idu_mem_op,
  input  logic                  idu_rd_wen,
  input  logic [ADDR_WIDTH-1:0] exu_next_pc,
  output logic                  lsu_req,
  output logic                  lsu_we,
  input  logic                  lsu_ack,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  retire,
  output logic                  halt,
  output logic [1:0]            halt_code,
  output logic [CNT_WIDTH-1:0]  cycle_cnt,
  output logic [CNT_WIDTH-1:0]  instret_cnt
);
  state_t                r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [31:0]           r_inst;
  logic [1:0]            r_code, w_code;
  logic [CNT_WIDTH-1:0]  r_cycle, r_instret;
  logic                  w_waiting, w_ack, w_expired;
  assign w_waiting = r_state == ST_FETCH || r_state == ST_MEM;
  assign w_ack     = r_state == ST_FETCH ? ifu_ack : lsu_ack;
  seq_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk       (clk),
    .rst_n     (rst),
    .i_clr     (!w_waiting),
    .i_en      (w_waiting && !w_ack),
    .o_expired (w_expired)
  );
  always_comb begin
    w_next = r_state;
    w_code = r_code;
    case (r_state)
      ST_FETCH, ST_MEM: begin
        w_next = w_ack ? (r_state == ST_FETCH ? ST_DECODE : ST_WB) : w_expired ? ST_HALT : r_state;
        w_code = (!w_ack && w_expired) ? HC_TIMEOUT : r_code;
      end
      ST_DECODE: begin
        w_next = (idu_illegal || idu_mem_op == 2'b11 || idu_ebreak) ? ST_HALT : ST_EXEC;
        w_code = (idu_illegal || idu_mem_op == 2'b11) ? HC_ILLEGAL : idu_ebreak ? HC_EBREAK : r_code;
      end
      ST_EXEC: begin
        w_next = exu_next_pc[1:0] != 2'b00 ? ST_HALT : idu_mem_op != MOP_NONE ? ST_MEM : ST_WB;
        w_code = exu_next_pc[1:0] != 2'b00 ? HC_MISALIGN : r_code;
      end
      ST_WB:   w_next = ST_FETCH;
      default: w_next = ST_HALT;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_FETCH;
      r_pc      <= RESET_PC;
      r_inst    <= '0;
      r_code    <= HC_EBREAK;
      r_cycle   <= '0;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      r_code  <= w_code;
      if (r_state == ST_FETCH && ifu_ack) r_inst <= ifu_rdata;
      if (r_state != ST_HALT) r_cycle <= r_cycle + 1'b1;
      if (r_state == ST_WB) begin
        r_pc      <= exu_next_pc;
        r_instret <= r_instret + 1'b1;
      end
    end
  end
  assign ifu_req     = r_state == ST_FETCH;
  assign ifu_addr    = r_pc;
  assign inst        = r_inst;
  assign lsu_req     = r_state == ST_MEM;
  assign lsu_we      = r_state == ST_MEM && idu_mem_op == MOP_STORE;
  assign rf_wen      = r_state == ST_WB && idu_rd_wen && idu_mem_op != MOP_STORE;
  assign retire      = r_state == ST_WB;
  assign pc          = r_pc;
  assign halt        = r_state == ST_HALT;
  assign halt_code   = r_code;
  assign cycle_cnt   = r_cycle;
  assign instret_cnt = r_instret;
endmodule

// File: tb/tb_core_seq_ctrl.sv
// tb_core_seq_ctrl: directed scenario tasks with hand-computed expectations for core_seq_ctrl.
module tb_core_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ifu_req, ifu_ack = 1'b0;
  logic [31:0] ifu_addr, ifu_rdata = '0, inst;
  logic        idu_illegal = 1'b0, idu_ebreak = 1'b0, idu_rd_wen = 1'b0;
  logic [1:0]  idu_mem_op = 2'b00;
  logic [31:0] exu_next_pc = '0;
  logic        lsu_req, lsu_we, lsu_ack = 1'b0;
  logic        rf_wen, retire, halt;
  logic [31:0] pc, cycle_cnt, instret_cnt;
  logic [1:0]  halt_code;
  int tests = 0, fails = 0;

  core_seq_ctrl dut (
    .clk(clk), .rst(rst), .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_ack(ifu_ack),
    .ifu_rdata(ifu_rdata), .inst(inst), .idu_illegal(idu_illegal), .idu_ebreak(idu_ebreak),
    .idu_mem_op(idu_mem_op), .idu_rd_wen(idu_rd_wen), .exu_next_pc(exu_next_pc),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_ack(lsu_ack), .rf_wen(rf_wen), .pc(pc),
    .retire(retire), .halt(halt), .halt_code(halt_code), .cycle_cnt(cycle_cnt),
    .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    ifu_ack = 1'b0; lsu_ack = 1'b0; idu_illegal = 1'b0; idu_ebreak = 1'b0;
    idu_mem_op = 2'b00; idu_rd_wen = 1'b0; exu_next_pc = 32'h8000_0000;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (ifu_req !== 1'b1 || lsu_req !== 1'b0 || rf_wen !== 1'b0 || retire !== 1'b0) begin fails++; $display("FAIL reset_strobes got ifu_req=%b lsu_req=%b rf_wen=%b retire=%b want 1 0 0 0", ifu_req, lsu_req, rf_wen, retire); end
    tests++; if (pc !== 32'h8000_0000 || ifu_addr !== 32'h8000_0000) begin fails++; $display("FAIL reset_pc got pc=%h addr=%h want 80000000", pc, ifu_addr); end
    tests++; if (inst !== 32'h0 || halt !== 1'b0 || halt_code !== 2'd0 || cycle_cnt !== 0 || instret_cnt !== 0) begin fails++; $display("FAIL reset_regs got inst=%h halt=%b code=%0d cyc=%0d ret=%0d want 0", inst, halt, halt_code, cycle_cnt, instret_cnt); end
  endtask

  task automatic test_alu();
    ifu_ack = 1'b1; ifu_rdata = 32'h0010_0093; idu_mem_op = 2'b00; idu_rd_wen = 1'b1;
    exu_next_pc = 32'h8000_0004;
    cyc();
    ifu_ack = 1'b0;
    tests++; if (inst !== 32'h0010_0093 || ifu_req !== 1'b0 || retire !== 1'b0) begin fails++; $display("FAIL alu_decode got inst=%h ifu_req=%b retire=%b want 00100093 0 0", inst, ifu_req, retire); end
    cyc();
    tests++; if (retire !== 1'b0 || rf_wen !== 1'b0) begin fails++; $display("FAIL alu_exec got retire=%b rf_wen=%b want 0 0", retire, rf_wen); end
    cyc();
    tests++; if (retire !== 1'b1 || rf_wen !== 1'b1) begin fails++; $display("FAIL alu_wb got retire=%b rf_wen=%b want 1 1", retire, rf_wen); end
    cyc();
    tests++; if (pc !== 32'h8000_0004 || instret_cnt !== 1 || cycle_cnt !== 4 || ifu_req !== 1'b1 || retire !== 1'b0) begin fails++; $display("FAIL alu_after got pc=%h ret=%0d cyc=%0d ifu_req=%b retire=%b want 80000004 1 4 1 0", pc, instret_cnt, cycle_cnt, ifu_req, retire); end
  endtask

  task automatic test_load();
    int req_cycles = 0;
    ifu_ack = 1'b1; ifu_rdata = 32'h0000_2103; idu_mem_op = 2'b01; idu_rd_wen = 1'b1;
    exu_next_pc = 32'h8000_0008;
    cyc();
    ifu_ack = 1'b1;
    tests++; if (lsu_req !== 1'b0) begin fails++; $display("FAIL load_decode_lsu got %b want 0", lsu_req); end
    cyc();
    ifu_ack = 1'b0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      if (lsu_req === 1'b1 && lsu_we === 1'b0) req_cycles++;
      lsu_ack = (i == 3);
      cyc();
    end
    lsu_ack = 1'b0;
    tests++; if (req_cycles !== 4) begin fails++; $display("FAIL load_req_cycles got %0d want 4", req_cycles); end
    tests++; if (lsu_req !== 1'b0 || rf_wen !== 1'b1 || retire !== 1'b1) begin fails++; $display("FAIL load_wb got lsu_req=%b rf_wen=%b retire=%b want 0 1 1", lsu_req, rf_wen, retire); end
    cyc();
    tests++; if (cycle_cnt !== 12 || instret_cnt !== 2 || pc !== 32'h8000_0008) begin fails++; $display("FAIL load_after got cyc=%0d ret=%0d pc=%h want 12 2 80000008", cycle_cnt, instret_cnt, pc); end
  endtask

  task automatic test_store();
    ifu_ack = 1'b1; ifu_rdata = 32'h0020_a023; idu_mem_op = 2'b10; idu_rd_wen = 1'b1;
    exu_next_pc = 32'h8000_000c;
    cyc();
    ifu_ack = 1'b0;
    cyc();
    cyc();
    tests++; if (lsu_req !== 1'b1 || lsu_we !== 1'b1) begin fails++; $display("FAIL store_mem got lsu_req=%b lsu_we=%b want 1 1", lsu_req, lsu_we); end
    lsu_ack = 1'b1;
    cyc();
    lsu_ack = 1'b0;
    tests++; if (rf_wen !== 1'b0 || retire !== 1'b1) begin fails++; $display("FAIL store_wb got rf_wen=%b retire=%b want 0 1", rf_wen, retire); end
    cyc();
    tests++; if (cycle_cnt !== 17 || instret_cnt !== 3 || pc !== 32'h8000_000c) begin fails++; $display("FAIL store_after got cyc=%0d ret=%0d pc=%h want 17 3 8000000c", cycle_cnt, instret_cnt, pc); end
  endtask

  task automatic test_illegal();
    int seen_req = 0;
    ifu_ack = 1'b1; ifu_rdata = 32'hffff_ffff; idu_mem_op = 2'b00; idu_illegal = 1'b1; idu_ebreak = 1'b1;
    exu_next_pc = 32'h8000_0010;
    cyc();
    ifu_ack = 1'b0;
    cyc();
    tests++; if (halt !== 1'b1 || halt_code !== 2'd1) begin fails++; $display("FAIL illegal_halt got halt=%b code=%0d want 1 1", halt, halt_code); end
    for (int i = 0; i < 6; i++) begin
      ifu_ack = i[0]; lsu_ack = !i[0];
      if (ifu_req !== 1'b0 || lsu_req !== 1'b0 || retire !== 1'b0) seen_req++;
      cyc();
    end
    ifu_ack = 1'b0; lsu_ack = 1'b0; idu_illegal = 1'b0; idu_ebreak = 1'b0;
    tests++; if (seen_req !== 0) begin fails++; $display("FAIL illegal_strobes got %0d strobe cycles want 0", seen_req); end
    tests++; if (cycle_cnt !== 19 || instret_cnt !== 3 || pc !== 32'h8000_000c || halt_code !== 2'd1 || inst !== 32'hffff_ffff) begin fails++; $display("FAIL illegal_frozen got cyc=%0d ret=%0d pc=%h code=%0d inst=%h want 19 3 8000000c 1 ffffffff", cycle_cnt, instret_cnt, pc, halt_code, inst); end
  endtask

  task automatic test_timeout();
    int early = 0;
    do_reset();
    for (int i = 1; i <= 255; i++) begin
      if (halt !== 1'b0 || ifu_req !== 1'b1) early++;
      cyc();
    end
    tests++; if (early !== 0) begin fails++; $display("FAIL timeout_early got %0d bad cycles want 0", early); end
    tests++; if (halt !== 1'b1 || halt_code !== 2'd2 || ifu_req !== 1'b0 || cycle_cnt !== 255) begin fails++; $display("FAIL timeout_halt got halt=%b code=%0d ifu_req=%b cyc=%0d want 1 2 0 255", halt, halt_code, ifu_req, cycle_cnt); end
  endtask

  task automatic test_ack_at_limit_and_misalign();
    do_reset();
    repeat (254) cyc();
    ifu_ack = 1'b1; ifu_rdata = 32'h0000_0013; idu_mem_op = 2'b00; idu_rd_wen = 1'b1;
    exu_next_pc = 32'h8000_0006;
    cyc();
    ifu_ack = 1'b0;
    tests++; if (halt !== 1'b0 || inst !== 32'h0000_0013) begin fails++; $display("FAIL ack_at_limit got halt=%b inst=%h want 0 00000013", halt, inst); end
    cyc();
    tests++; if (halt !== 1'b0 || retire !== 1'b0) begin fails++; $display("FAIL misalign_exec got halt=%b retire=%b want 0 0", halt, retire); end
    cyc();
    tests++; if (halt !== 1'b1 || halt_code !== 2'd3 || retire !== 1'b0 || instret_cnt !== 0 || pc !== 32'h8000_0000) begin fails++; $display("FAIL misalign_halt got halt=%b code=%0d retire=%b ret=%0d pc=%h want 1 3 0 0 80000000", halt, halt_code, retire, instret_cnt, pc); end
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    ifu_ack = 1'b1; ifu_rdata = 32'h0000_2103; idu_mem_op = 2'b01; idu_rd_wen = 1'b1;
    exu_next_pc = 32'h8000_0004;
    cyc();
    ifu_ack = 1'b0;
    repeat (3) cyc();
    tests++; if (lsu_req !== 1'b1) begin fails++; $display("FAIL mid_mem_req got %b want 1", lsu_req); end
    #2 rst = 1'b0;
    #1;
    tests++; if (lsu_req !== 1'b0 || lsu_we !== 1'b0 || ifu_req !== 1'b1) begin fails++; $display("FAIL async_reset got lsu_req=%b lsu_we=%b ifu_req=%b want 0 0 1", lsu_req, lsu_we, ifu_req); end
    lsu_ack = 1'b1; ifu_ack = 1'b1;
    cyc();
    lsu_ack = 1'b0; ifu_ack = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++; if (ifu_req !== 1'b1 || pc !== 32'h8000_0000 || cycle_cnt !== 0 || instret_cnt !== 0 || halt !== 1'b0 || inst !== 32'h0) begin fails++; $display("FAIL post_reset got ifu_req=%b pc=%h cyc=%0d ret=%0d halt=%b inst=%h want 1 80000000 0 0 0 0", ifu_req, pc, cycle_cnt, instret_cnt, halt, inst); end
    cyc();
    tests++; if (ifu_req !== 1'b1 || lsu_req !== 1'b0 || cycle_cnt !== 1) begin fails++; $display("FAIL post_reset_fetch got ifu_req=%b lsu_req=%b cyc=%0d want 1 0 1", ifu_req, lsu_req, cycle_cnt); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_illegal();
    test_timeout();
    test_ack_at_limit_and_misalign();
    test_reset_mid_mem();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/core_seq_ctrl.md
Name: core_seq_ctrl

Overview:
- Multi-cycle sequencer for the NPC core.
- Drives instruction fetch, holds the fetched instruction for the decoder, and steps the datapath through decode, execute, memory and writeback.
- Owns the PC, the register-file write strobe, halt reporting and the cycle/instret counters.
- Sits between the instruction/data memory handshakes and the combinational IDU/EXU datapath.

Parameters:
- ADDR_WIDTH, 32, PC and memory address width.
- RESET_PC, 32'h8000_0000, PC value loaded at reset.
- TIMEOUT_CYCLES, 255, maximum cycles to wait for a memory ack before halting.
- CNT_WIDTH, 32, width of the cycle and instret counters.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset.
- ifu_req  out  1  instruction fetch request.
- ifu_addr  out  ADDR_WIDTH  fetch address; always equals pc.
- ifu_ack  in  1  fetch complete; ifu_rdata valid this cycle.
- ifu_rdata  in  32  fetched instruction.
- inst  out  32  latched instruction presented to the decoder.
- idu_illegal  in  1  decoder reports an unknown opcode.
- idu_ebreak  in  1  decoder reports ebreak.
- idu_mem_op  in  2  memory operation: 00 none, 01 load, 10 store (11 is treated as illegal).
- idu_rd_wen  in  1  instruction writes rd.
- exu_next_pc  in  ADDR_WIDTH  next PC from the EXU.
- lsu_req  out  1  data memory request.
- lsu_we  out  1  1 = store, 0 = load; valid while lsu_req is high.
- lsu_ack  in  1  data access complete.
- rf_wen  out  1  register-file write strobe, one cycle wide.
- pc  out  ADDR_WIDTH  current PC.
- retire  out  1  one-cycle pulse per retired instruction.
- halt  out  1  sticky halt flag.
- halt_code  out  2  0 ebreak, 1 illegal, 2 timeout, 3 misaligned next PC.
- cycle_cnt  out  CNT_WIDTH  cycles since reset, excluding cycles spent in HALT.
- instret_cnt  out  CNT_WIDTH  retired instruction count.

Behaviour:
- Reset (rst=0, asynchronous): state=FETCH, pc=RESET_PC, inst=0, halt=0, halt_code=0, both counters=0.
  - All strobes (ifu_req, lsu_req, lsu_we, rf_wen, retire) are decoded from state and fall immediately.
  - A reset during any state aborts the operation in progress; any outstanding ack after reset is ignored.
- State machine: FETCH, DECODE, EXEC, MEM, WB, HALT. Fixed encoding; each state is registered.
- FETCH:
  - ifu_req=1 throughout.
  - On ifu_ack: inst<=ifu_rdata, next state DECODE.
  - An ack in the first FETCH cycle is valid.
- DECODE (1 cycle):
  - idu_illegal, or idu_mem_op=11 → HALT, code 1.
  - Otherwise idu_ebreak → HALT, code 0.
  - Otherwise → EXEC.
  - illegal has priority over ebreak.
- EXEC (1 cycle):
  - exu_next_pc[1:0]≠0 → HALT, code 3.
  - Otherwise idu_mem_op≠00 → MEM, else → WB.
- MEM:
  - lsu_req=1 and lsu_we=(idu_mem_op==10) throughout.
  - On lsu_ack → WB.
- WB (1 cycle):
  - rf_wen=idu_rd_wen & (idu_mem_op≠10).
  - retire=1; pc<=exu_next_pc; instret_cnt++.
  - Next state FETCH.
- HALT:
  - Absorbing until reset; halt=1, halt_code frozen.
  - No strobes asserted; pc, inst and both counters frozen.
- Timeout: a single wait counter is cleared on entry to FETCH or MEM and increments every cycle without an ack.
  - Reaching TIMEOUT_CYCLES without an ack → HALT, code 2.
  - An ack arriving in the same cycle the limit is reached wins; no timeout is taken.
- Acks arriving in any state other than their own (ifu_ack outside FETCH, lsu_ack outside MEM) are ignored.
- inst is stable from DECODE through WB; the IDU/EXU inputs are sampled only in the states listed above.
- cycle_cnt increments in every non-HALT cycle. Both counters wrap modulo 2^CNT_WIDTH silently.
- Minimum latency per instruction: 4 cycles without a memory access (FETCH with immediate ack, DECODE, EXEC, WB); 5 cycles with one.

Decomposition:
- Shared package holds:
  - state encoding;
  - halt code constants (EBREAK=0, ILLEGAL=1, TIMEOUT=2, MISALIGN=3);
  - mem_op constants (NONE=00, LOAD=01, STORE=10);
  - RESET_PC default.
- One sub-module, seq_wait_timer: clear/enable inputs, expired output, parameter TIMEOUT_CYCLES. Shared by FETCH and MEM.

Test Plan:
- Reset release, ifu_ack in the first cycle, ifu_rdata=32'h00100093, mem_op=00, rd_wen=1, next_pc=8000_0004:
  - retire and rf_wen pulse in cycle 4;
  - pc=8000_0004, instret_cnt=1, cycle_cnt=4.
- Load with lsu_ack delayed 3 cycles:
  - lsu_req high for 4 cycles with lsu_we=0;
  - rf_wen=1 in WB;
  - total 8 cycles for the instruction.
- Store, idu_rd_wen=1:
  - lsu_we=1 during MEM;
  - rf_wen stays 0 in WB; retire=1.
- idu_illegal=1 together with idu_ebreak=1 in DECODE:
  - halt=1, halt_code=1;
  - no further ifu_req; counters frozen.
- Timeout and misalignment:
  - ifu_ack withheld → halt_code=2 after exactly 255 FETCH cycles;
  - rerun with the ack arriving in cycle 255 → no halt;
  - exu_next_pc=8000_0006 → halt_code=3, no retire.
- Reset asserted mid-MEM, then lsu_ack pulsed while rst=0:
  - lsu_req drops immediately;
  - after release: state FETCH, pc=8000_0000, counters=0, halt=0.
